// File: rtl/linebuf_pkg.sv
// Shared types and helpers for the ping-pong pixel line buffer.
package linebuf_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } wstate_t;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  function automatic int pix_bus_w(input int channels, input int pix_w);
    return channels * pix_w;
  endfunction

endpackage

// File: rtl/linebuf_bank.sv
// One line bank: DEPTH x WIDTH RAM, synchronous write, registered read.
module linebuf_bank #(
  parameter int DEPTH  = 100,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents survive reset, and rdata only moves on a read.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_pp.sv
// Double-buffered pixel line buffer: valid/ready line fill, random-access scan-out.
// Optional build macro LINEBUF_UNDERRUN_CNT_EN adds a saturating underrun counter.
module line_buffer_pp
  import linebuf_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 100,
  parameter int LINES    = 100,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ROW_W    = $clog2(LINES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CHANNELS*PIX_W-1:0] wr_data,
  output logic                      line_ready,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_valid,
  output logic [CHANNELS*PIX_W-1:0] rd_pixel,
  output logic [ROW_W-1:0]          row,
  input  logic                      line_done,
  output logic                      underrun
`ifdef LINEBUF_UNDERRUN_CNT_EN
  , output logic [15:0]             underrun_cnt
`endif
);

  localparam int BUS_W = pix_bus_w(CHANNELS, PIX_W);

  wstate_t           wstate, next_state;
  logic [ADDR_W-1:0] wptr;
  logic              wbank;
  logic [ROW_W-1:0]  wline;
  logic              rd_bank_valid;
  logic              rd_sel;
  logic              rd_zero;
  logic              accept, last_beat, swap, addr_ok;
  logic [BUS_W-1:0]  q0, q1;

  assign addr_ok = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);

  always_comb begin
    next_state = wstate;
    accept     = wr_valid && wr_ready;
    last_beat  = accept && (wptr == ADDR_W'(DEPTH - 1));
    swap       = line_done && ((wstate == FULL) || last_beat);
    case (wstate)
      FILLING: if (last_beat) next_state = FULL;
      FULL:    next_state = FULL;
      default: next_state = FILLING;
    endcase
    if (swap) next_state = FILLING;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate        <= FILLING;
      wptr          <= '0;
      wbank         <= BANK0;
      wline         <= '0;
      rd_bank_valid <= 1'b0;
      wr_ready      <= 1'b0;
      line_ready    <= 1'b0;
      row           <= '0;
      underrun      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_zero       <= 1'b1;
      rd_sel        <= BANK1;
    end else begin
      wstate     <= next_state;
      wr_ready   <= (next_state == FILLING);
      line_ready <= (next_state == FULL);
      underrun   <= line_done && !swap;
      rd_valid   <= rd_en;
      if (accept) wptr <= last_beat ? '0 : wptr + 1'b1;
      if (swap) begin
        wbank         <= ~wbank;
        rd_bank_valid <= 1'b1;
        row           <= wline;
        wline         <= (wline == ROW_W'(LINES - 1)) ? '0 : wline + 1'b1;
      end
      // Read selection latched from pre-swap state so a coincident read sees the old line.
      if (rd_en) begin
        rd_zero <= !rd_bank_valid || !addr_ok;
        rd_sel  <= ~wbank;
      end
    end
  end

`ifdef LINEBUF_UNDERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) underrun_cnt <= '0;
    else if (line_done && !swap && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

  linebuf_bank #(.DEPTH(DEPTH), .WIDTH(BUS_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clock (clock),
    .we    (accept && (wbank == BANK0)),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (rd_en && addr_ok),
    .raddr (rd_addr),
    .rdata (q0)
  );

  linebuf_bank #(.DEPTH(DEPTH), .WIDTH(BUS_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clock (clock),
    .we    (accept && (wbank == BANK1)),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (rd_en && addr_ok),
    .raddr (rd_addr),
    .rdata (q1)
  );

  assign rd_pixel = rd_zero ? '0 : ((rd_sel == BANK0) ? q0 : q1);

endmodule

// File: tb/tb_line_buffer_pp.sv
// Scoreboard bench for line_buffer_pp against a line-level reference model.
module tb_line_buffer_pp;

  localparam int PIX_W    = 8;
  localparam int CHANNELS = 3;
  localparam int DEPTH    = 100;
  localparam int LINES    = 100;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int ROW_W    = $clog2(LINES);
  localparam int BW       = CHANNELS * PIX_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [BW-1:0]     wr_data = '0;
  logic              line_ready;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [BW-1:0]     rd_pixel;
  logic [ROW_W-1:0]  row;
  logic              line_done = 1'b0;
  logic              underrun;
`ifdef LINEBUF_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  line_buffer_pp #(
    .PIX_W(PIX_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .LINES(LINES),
    .ADDR_W(ADDR_W), .ROW_W(ROW_W)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .line_ready(line_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_pixel(rd_pixel),
    .row(row), .line_done(line_done), .underrun(underrun)
`ifdef LINEBUF_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: the line on display plus the pixels gathered so far for the next one.
  logic [BW-1:0] shown [DEPTH];
  logic [BW-1:0] pend [$];
  logic [BW-1:0] exp_q [$];
  bit            m_shown_valid = 0;
  int            m_row = 0;
  int            m_wline = 0;
  bit            m_ready = 0;
  bit            m_lr = 0;
  bit            m_under = 0;
  int            m_ucnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_pixel", 32'(rd_pixel), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit wv, input logic [BW-1:0] wd, input bit re,
                      input logic [ADDR_W-1:0] ra, input bit ld);
    @(negedge clock);
    chk("wr_ready", 32'(wr_ready), 32'(m_ready));
    chk("line_ready", 32'(line_ready), 32'(m_lr));
    chk("row", 32'(row), 32'(m_row));
    chk("underrun", 32'(underrun), 32'(m_under));
`ifdef LINEBUF_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
    wr_valid  = wv;
    wr_data   = wd;
    rd_en     = re;
    rd_addr   = ra;
    line_done = ld;
    if (re) begin
      if (!m_shown_valid || int'(ra) >= DEPTH) exp_q.push_back('0);
      else exp_q.push_back(shown[ra]);
    end
    if (wv && m_ready) pend.push_back(wd);
    m_under = 0;
    if (ld) begin
      if (pend.size() == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) shown[i] = pend[i];
        pend.delete();
        m_shown_valid = 1;
        m_row   = m_wline;
        m_wline = (m_wline + 1) % LINES;
      end else begin
        m_under = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end
    end
    m_ready = (pend.size() < DEPTH);
    m_lr    = (pend.size() == DEPTH);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
  endtask

  task automatic rd(input int a);
    step(0, '0, 1, ADDR_W'(a), 0);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1; wr_valid = 0; rd_en = 0; line_done = 1'b1;
    pend.delete();
    m_shown_valid = 0; m_row = 0; m_wline = 0; m_lr = 0; m_under = 0; m_ucnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      line_done = (i == 0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_line_ready", 32'(line_ready), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_pixel", 32'(rd_pixel), 32'd0);
      chk("rst_row", 32'(row), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
    end
    reset = 1'b0; line_done = 1'b0;
    m_ready = 1;
  endtask

  // Accepts n beats; optional random gaps, random reads, stray line_done, and line_done on the final beat.
  task automatic fill(input int n, input bit rnd, input bit ld_last, input bit seq);
    int got = 0;
    int guard = 0;
    bit wv, re, ld;
    logic [BW-1:0] wd;
    logic [ADDR_W-1:0] ra;
    while (got < n && guard < 4 * DEPTH + 50) begin
      wv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      wd = seq ? BW'(pend.size()) : BW'($urandom);
      re = rnd && ($urandom_range(0, 2) == 0);
      ra = ADDR_W'($urandom_range(0, 127));
      ld = ld_last && wv && m_ready && (got == n - 1);
      if (rnd && !ld_last && $urandom_range(0, 199) == 0) ld = 1'b1;
      if (wv && m_ready) got++;
      step(wv, wd, re, ra, ld);
      guard++;
    end
    if (got < n) chk("fill_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    reset_dut();

    // First line 0..99, then swap and read back.
    fill(DEPTH, 0, 0, 1);
    idle(2);
    chk("line_ready_after_fill", 32'(line_ready), 32'd1);
    chk("wr_ready_after_fill", 32'(wr_ready), 32'd0);
    step(0, '0, 0, '0, 1);
    idle(1);
    chk("row_first_swap", 32'(row), 32'd0);
    rd(5);
    rd(100);
    idle(2);

    // Early line_done: underrun, line repeats, fill continues.
    fill(40, 0, 0, 0);
    step(0, '0, 0, '0, 1);
    step(0, '0, 1, ADDR_W'(5), 0);
    chk("underrun_pulse", 32'(underrun), 32'd1);
    chk("row_hold", 32'(row), 32'd0);
    fill(DEPTH - 41, 0, 0, 0);
    chk("line_ready_before_last", 32'(line_ready), 32'd0);

    // Final beat coincident with line_done.
    fill(1, 0, 1, 0);
    idle(1);
    chk("row_coincident_swap", 32'(row), 32'd1);
    rd(99);
    rd(0);
    idle(2);

    // Reset mid-fill: partial line discarded, reads zero until a swap.
    fill(50, 0, 0, 0);
    reset_dut();
    rd(5);
    rd(0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 1);
    idle(1);
`ifdef LINEBUF_UNDERRUN_CNT_EN
    chk("underrun_cnt_three", 32'(underrun_cnt), 32'd3);
`endif
    chk("row_after_reset", 32'(row), 32'd0);

    // LINES+1 lines with random gaps and reads; rows 0..LINES-1 then wrap to 0.
    for (int l = 0; l < LINES + 1; l++) begin
      fill(DEPTH, 1, 0, 0);
      for (int k = 0; k < 2; k++) step(0, '0, 1, ADDR_W'($urandom_range(0, 127)), 0);
      step(0, '0, 1, ADDR_W'($urandom_range(0, DEPTH - 1)), 1);
      step(0, '0, 1, '0, 0);
      chk("row_seq", 32'(row), 32'(l % LINES));
    end

    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
